// File: rtl/temp_monitor_mc.sv
// Multi-channel temperature alarm monitor with hysteresis and consecutive-sample debounce.
// Optional per-channel peak tracking is built when TEMP_MON_PEAK_EN is defined.
module temp_monitor_mc #(
  parameter int NUM_CH   = 4,
  parameter int TEMP_W   = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH*TEMP_W-1:0] temp_i,
  input  logic [NUM_CH-1:0]        temp_valid_i,
  input  logic [TEMP_W-1:0]        th_hi_i,
  input  logic [TEMP_W-1:0]        th_lo_i,
  input  logic [NUM_CH-1:0]        clr_sticky_i,
  output logic [NUM_CH-1:0]        alarm_o,
  output logic [NUM_CH-1:0]        alarm_sticky_o,
  output logic                     alarm_any_o,
  output logic                     cfg_err_o
`ifdef TEMP_MON_PEAK_EN
  ,
  output logic [NUM_CH*TEMP_W-1:0] peak_o
`endif
);

  // state   | meaning
  // NORMAL  | no alarm, no run in progress
  // ARMING  | no alarm, counting consecutive hot samples
  // HOT     | alarm active
  // COOLING | alarm active, counting consecutive cool samples
  localparam logic [1:0] NORMAL  = 2'b00;
  localparam logic [1:0] ARMING  = 2'b01;
  localparam logic [1:0] HOT     = 2'b10;
  localparam logic [1:0] COOLING = 2'b11;

  localparam int            CW    = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [1:0]        state_q [NUM_CH];
  logic [1:0]        state_d [NUM_CH];
  logic [CW-1:0]     cnt_q   [NUM_CH];
  logic [CW-1:0]     cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] hot, cool;
  logic [NUM_CH-1:0] alarm_q, alarm_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic              alarm_any_q;
  logic              cfg_err_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hot[i]  = temp_valid_i[i] && (temp_i[i*TEMP_W +: TEMP_W] > th_hi_i);
      cool[i] = temp_valid_i[i] && (temp_i[i*TEMP_W +: TEMP_W] < th_lo_i);
    end
  end

  // Counter is cleared whenever a run completes so each new run starts from zero.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        NORMAL: begin
          if (hot[i]) begin
            cnt_d[i]   = (DEBOUNCE == 1) ? '0 : ONE_C;
            state_d[i] = (DEBOUNCE == 1) ? HOT : ARMING;
          end
        end
        ARMING: begin
          if (hot[i]) begin
            if (cnt_q[i] + ONE_C == DEB_C) begin
              cnt_d[i]   = '0;
              state_d[i] = HOT;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE_C;
            end
          end else if (temp_valid_i[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = NORMAL;
          end
        end
        HOT: begin
          if (cool[i]) begin
            cnt_d[i]   = (DEBOUNCE == 1) ? '0 : ONE_C;
            state_d[i] = (DEBOUNCE == 1) ? NORMAL : COOLING;
          end
        end
        default: begin
          if (cool[i]) begin
            if (cnt_q[i] + ONE_C == DEB_C) begin
              cnt_d[i]   = '0;
              state_d[i] = NORMAL;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE_C;
            end
          end else if (temp_valid_i[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = HOT;
          end
        end
      endcase
    end
  end

  // A rising alarm beats a coincident sticky clear.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      alarm_d[i]  = (state_d[i] == HOT) || (state_d[i] == COOLING);
      sticky_d[i] = sticky_q[i];
      if (alarm_d[i] && !alarm_q[i]) begin
        sticky_d[i] = 1'b1;
      end else if (clr_sticky_i[i]) begin
        sticky_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= NORMAL;
        cnt_q[i]   <= '0;
      end
      alarm_q     <= '0;
      sticky_q    <= '0;
      alarm_any_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      alarm_q     <= alarm_d;
      sticky_q    <= sticky_d;
      alarm_any_q <= |alarm_q;
      cfg_err_q   <= (th_lo_i > th_hi_i);
    end
  end

  assign alarm_o        = alarm_q;
  assign alarm_sticky_o = sticky_q;
  assign alarm_any_o    = alarm_any_q;
  assign cfg_err_o      = cfg_err_q;

`ifdef TEMP_MON_PEAK_EN
  logic [TEMP_W-1:0] peak_q [NUM_CH];
  logic [TEMP_W-1:0] peak_d [NUM_CH];

  // A clear restarts tracking from zero, so any coincident valid sample wins.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      peak_d[i] = peak_q[i];
      if (clr_sticky_i[i]) begin
        peak_d[i] = temp_valid_i[i] ? temp_i[i*TEMP_W +: TEMP_W] : '0;
      end else if (temp_valid_i[i] && (temp_i[i*TEMP_W +: TEMP_W] > peak_q[i])) begin
        peak_d[i] = temp_i[i*TEMP_W +: TEMP_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst_i) begin
        peak_q[i] <= '0;
      end else begin
        peak_q[i] <= peak_d[i];
      end
    end
  end

  always_comb begin
    peak_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      peak_o[i*TEMP_W +: TEMP_W] = peak_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_temp_monitor_mc.sv
// Bench for temp_monitor_mc: directed scenarios plus random traffic against a run-length model.
// Peak checks are compiled in when TEMP_MON_PEAK_EN is defined.
module tb_temp_monitor_mc;
  localparam int NUM_CH = 4;
  localparam int TEMP_W = 8;
  localparam int DEB    = 3;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NUM_CH*TEMP_W-1:0] temp_i;
  logic [NUM_CH-1:0]        temp_valid_i;
  logic [TEMP_W-1:0]        th_hi_i, th_lo_i;
  logic [NUM_CH-1:0]        clr_sticky_i;
  logic [NUM_CH-1:0]        alarm_o, alarm_sticky_o;
  logic                     alarm_any_o, cfg_err_o;
`ifdef TEMP_MON_PEAK_EN
  logic [NUM_CH*TEMP_W-1:0] peak_o;
`endif

  temp_monitor_mc #(.NUM_CH(NUM_CH), .TEMP_W(TEMP_W), .DEBOUNCE(DEB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .temp_i(temp_i), .temp_valid_i(temp_valid_i),
    .th_hi_i(th_hi_i), .th_lo_i(th_lo_i), .clr_sticky_i(clr_sticky_i),
    .alarm_o(alarm_o), .alarm_sticky_o(alarm_sticky_o), .alarm_any_o(alarm_any_o),
    .cfg_err_o(cfg_err_o)
`ifdef TEMP_MON_PEAK_EN
    , .peak_o(peak_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Model: alarm flag per channel and length of the current qualifying run.
  bit m_alarm [NUM_CH];
  int m_run   [NUM_CH];
  bit m_sticky[NUM_CH];
  int m_peak  [NUM_CH];
  bit m_any, m_cfg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] vec(input bit a[NUM_CH]);
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic set_ch(input int ch, input int t, input bit v);
    temp_i[ch*TEMP_W +: TEMP_W] = TEMP_W'(t);
    temp_valid_i[ch] = v;
  endtask

  // One clock: predict from the inputs being sampled, then compare all outputs.
  task automatic step();
    bit n_alarm[NUM_CH];
    int n_run[NUM_CH];
    bit n_sticky[NUM_CH];
    int n_peak[NUM_CH];
    bit n_any, n_cfg;
    logic [NUM_CH*TEMP_W-1:0] exp_peak;
    n_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) n_any |= m_alarm[i];
    n_cfg = (th_lo_i > th_hi_i);
    for (int i = 0; i < NUM_CH; i++) begin
      int  t;
      bit  v, qual;
      t = int'(temp_i[i*TEMP_W +: TEMP_W]);
      v = temp_valid_i[i];
      qual = m_alarm[i] ? (v && t < int'(th_lo_i)) : (v && t > int'(th_hi_i));
      n_alarm[i] = m_alarm[i];
      n_run[i]   = m_run[i];
      if (qual) begin
        n_run[i] = m_run[i] + 1;
        if (n_run[i] == DEB) begin
          n_alarm[i] = !m_alarm[i];
          n_run[i]   = 0;
        end
      end else if (v) begin
        n_run[i] = 0;
      end
      n_sticky[i] = (n_alarm[i] && !m_alarm[i]) ? 1'b1 : (clr_sticky_i[i] ? 1'b0 : m_sticky[i]);
      if (clr_sticky_i[i]) n_peak[i] = v ? t : 0;
      else                 n_peak[i] = (v && t > m_peak[i]) ? t : m_peak[i];
      if (rst_i) begin
        n_alarm[i] = 0; n_run[i] = 0; n_sticky[i] = 0; n_peak[i] = 0;
      end
    end
    if (rst_i) begin
      n_any = 0; n_cfg = 0;
    end
    @(posedge clk_i);
    #1;
    m_alarm = n_alarm; m_run = n_run; m_sticky = n_sticky; m_peak = n_peak;
    m_any = n_any; m_cfg = n_cfg;
    check("alarm", alarm_o, vec(m_alarm));
    check("sticky", alarm_sticky_o, vec(m_sticky));
    check("alarm_any", alarm_any_o, m_any);
    check("cfg_err", cfg_err_o, m_cfg);
`ifdef TEMP_MON_PEAK_EN
    for (int i = 0; i < NUM_CH; i++) exp_peak[i*TEMP_W +: TEMP_W] = TEMP_W'(m_peak[i]);
    check("peak", peak_o, exp_peak);
`else
    exp_peak = '0;
`endif
  endtask

  task automatic idle(input int n);
    temp_valid_i = '0;
    clr_sticky_i = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic burst(input int ch, input int t, input int n);
    clr_sticky_i = '0;
    temp_valid_i = '0;
    set_ch(ch, t, 1'b1);
    for (int k = 0; k < n; k++) step();
    temp_valid_i = '0;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_alarm[i] = 0; m_run[i] = 0; m_sticky[i] = 0; m_peak[i] = 0;
    end
    m_any = 0; m_cfg = 0;
    temp_i = '0; temp_valid_i = '0; clr_sticky_i = '0;
    th_hi_i = 8'd57; th_lo_i = 8'd50;

    // Reset held two cycles with a hot ch0 sample present
    rst_i = 1'b1;
    set_ch(0, 90, 1'b1);
    step(); step();
    check("rst_alarm", alarm_o, 0);
    rst_i = 1'b0;
    step(); step();
    check("rst_no_early", alarm_o[0], 0);
    step();
    check("rst_rearm", alarm_o[0], 1);
    burst(0, 40, 3);
    check("ch0_cleared", alarm_o[0], 0);

    // Debounce survives a gap; threshold itself is not hot
    burst(0, 58, 2);
    idle(5);
    check("gap_pending", alarm_o[0], 0);
    burst(0, 58, 1);
    check("gap_alarm", alarm_o[0], 1);
    burst(0, 40, 3);
    burst(0, 57, 3);
    check("strict_hi", alarm_o[0], 0);

    // Hysteresis with aborted cooling run
    burst(1, 70, 3);
    burst(1, 49, 2);
    burst(1, 55, 1);
    burst(1, 49, 2);
    check("hyst_hold", alarm_o[1], 1);
    burst(1, 49, 1);
    check("hyst_clear", alarm_o[1], 0);

    // Sticky clear, then clear coincident with a new alarm
    burst(2, 70, 3);
    burst(2, 40, 3);
    check("sticky_kept", alarm_sticky_o[2], 1);
    idle(0);
    clr_sticky_i[2] = 1'b1;
    step();
    clr_sticky_i[2] = 1'b0;
    check("sticky_clr", alarm_sticky_o[2], 0);
    burst(2, 70, 2);
    set_ch(2, 70, 1'b1);
    clr_sticky_i[2] = 1'b1;
    step();
    clr_sticky_i[2] = 1'b0;
    temp_valid_i = '0;
    check("sticky_set_wins", alarm_sticky_o[2], 1);
    burst(2, 40, 3);

    // Simultaneous channels and aggregate, then inverted thresholds
    idle(1);
    temp_valid_i = '0;
    set_ch(0, 70, 1'b1);
    set_ch(3, 80, 1'b1);
    step(); step(); step();
    check("indep", alarm_o, 4'b1001);
    check("any_lag", alarm_any_o, 0);
    idle(1);
    check("any", alarm_any_o, 1);
    th_lo_i = 8'd60;
    idle(1);
    check("cfg_err", cfg_err_o, 1);
    th_lo_i = 8'd50;
    idle(1);

`ifdef TEMP_MON_PEAK_EN
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    burst(0, 40, 1);
    burst(0, 72, 1);
    burst(0, 65, 1);
    check("peak_max", peak_o[7:0], 72);
    set_ch(0, 30, 1'b1);
    clr_sticky_i[0] = 1'b1;
    step();
    clr_sticky_i = '0;
    temp_valid_i = '0;
    check("peak_clr_load", peak_o[7:0], 30);
`endif

    // Random traffic around the thresholds
    for (int k = 0; k < 3000; k++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) begin
        th_hi_i = TEMP_W'($urandom_range(45, 65));
        th_lo_i = TEMP_W'($urandom_range(40, 60));
      end
      for (int i = 0; i < NUM_CH; i++) begin
        int t;
        t = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(40, 70);
        set_ch(i, t, ($urandom_range(0, 2) != 0));
        clr_sticky_i[i] = ($urandom_range(0, 19) == 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/temp_monitor_mc.md
# temp_monitor_mc

Multi-channel successor to the single-threshold temperature comparator. Monitors `NUM_CH` independent °C sample streams against a programmable high/low threshold pair. Each channel applies hysteresis and a consecutive-sample debounce before raising or dropping its alarm. Sits downstream of the per-sensor °F→°C converters and feeds the system fault aggregator.

## Interface
- `NUM_CH`, 4: number of monitored channels (1–16).
- `TEMP_W`, 8: width of each unsigned °C sample and of each threshold.
- `DEBOUNCE`, 3: number of consecutive qualifying valid samples needed for a state change (1–255).
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `temp`  in  `NUM_CH*TEMP_W`: packed samples; channel i is in `[i*TEMP_W +: TEMP_W]`.
- `temp_valid`  in  `NUM_CH`: per-channel sample strobe.
- `th_hi`  in  `TEMP_W`: alarm-raise threshold, shared by all channels.
- `th_lo`  in  `TEMP_W`: alarm-clear threshold, shared by all channels.
- `clr_sticky`  in  `NUM_CH`: per-channel sticky-flag clear.
- `alarm`  out  `NUM_CH`: registered live alarm per channel.
- `alarm_sticky`  out  `NUM_CH`: latched record that an alarm occurred.
- `alarm_any`  out  1: registered OR of `alarm`.
- `cfg_err`  out  1: registered flag, high when `th_lo > th_hi`.
- `peak`  out  `NUM_CH*TEMP_W`: per-channel peak value. Present only with `TEMP_MON_PEAK_EN`.

## Operation
- Each channel has a 4-state FSM plus a debounce counter of width `$clog2(DEBOUNCE+1)`.
- "Hot" sample: `temp_valid[i]` is high and `temp_i > th_hi` (strict).
- "Cool" sample: `temp_valid[i]` is high and `temp_i < th_lo` (strict).
- All compares are unsigned.
- State NORMAL (`alarm` = 0):
  - hot sample: cnt = 1; go to HOT if `DEBOUNCE` = 1, else to ARMING.
- State ARMING (`alarm` = 0):
  - hot sample: cnt + 1; go to HOT when the incremented cnt reaches `DEBOUNCE`.
  - any other valid sample: cnt = 0, go to NORMAL.
- State HOT (`alarm` = 1):
  - cool sample: cnt = 1; go to NORMAL if `DEBOUNCE` = 1, else to COOLING.
- State COOLING (`alarm` = 1):
  - cool sample: cnt + 1; go to NORMAL when cnt reaches `DEBOUNCE`.
  - any other valid sample: cnt = 0, go to HOT.
- When `temp_valid[i]` is low: state and counter hold. Gaps never break a debounce run.
- Samples with `th_lo ≤ temp ≤ th_hi`:
  - in NORMAL or HOT: no effect.
  - in ARMING or COOLING: abort the run (the "any other valid sample" rule).
- `alarm_sticky[i]`:
  - set in the same cycle `alarm[i]` is set;
  - cleared by `clr_sticky[i]`;
  - set wins if both occur in the same cycle.
- `cfg_err`: evaluated every cycle; it does not gate the FSMs.
  - With `th_lo > th_hi`, a channel may toggle every `DEBOUNCE` samples; this is legal but flagged.
- Threshold changes take effect on the next valid sample; no state is re-evaluated retroactively.

## Timing
- Reset: all FSMs go to NORMAL, counters to 0. `alarm`, `alarm_sticky`, `alarm_any`, `cfg_err` and `peak` all reset to 0.
- Alarm latency: `alarm[i]` rises on the edge that samples the `DEBOUNCE`-th consecutive hot sample, and is visible the following cycle. Clearing has the same latency.
- `alarm_any`: one cycle after `alarm`.
- `cfg_err`: one cycle after the thresholds change.
- Reset mid-run: the partial count is discarded and outputs drop on the reset edge. The first post-reset valid sample starts a fresh run.
- Channels are fully independent. Simultaneous events on different channels never interact.

## Configuration
- `TEMP_MON_PEAK_EN` defined:
  - the `peak` port and per-channel `TEMP_W` peak registers are built;
  - on a valid sample with `temp_i > peak_i`, the register loads `temp_i` next cycle;
  - `clr_sticky[i]` also zeroes `peak_i`; when it coincides with a higher valid sample, the sample value is loaded.
- `TEMP_MON_PEAK_EN` undefined: the `peak` port and its registers are absent. All other behaviour is identical.

## Test plan
Common configuration: `NUM_CH`=4, `DEBOUNCE`=3, `th_hi`=57, `th_lo`=50.
- Reset: hold `rst` for 2 cycles with ch0 temp 90 valid -> all outputs 0. `alarm[0]` rises 3 valid samples after `rst` falls.
- Debounce with gap: ch0 samples 58, 58, (valid low 5 cycles), 58 -> `alarm[0]`=1 exactly one cycle after the third valid 58. Samples 57, 57, 57 -> no alarm (strict compare).
- Hysteresis/abort: ch1 in HOT, samples 49, 49, 55, 49, 49, 49 -> `alarm[1]` stays 1 until the final 49, then 0 next cycle.
- Sticky clear:
  - with `alarm_sticky[2]`=1, pulse `clr_sticky[2]` while `alarm[2]` is 0 -> sticky 0;
  - clear pulse coincident with a new alarm set -> sticky stays 1.
- Independence and aggregate: ch0 and ch3 reach HOT on the same cycle -> `alarm`=4'b1001, `alarm_any`=1 one cycle later. Set `th_lo`=60 -> `cfg_err`=1 next cycle.
- `TEMP_MON_PEAK_EN`: ch0 samples 40, 72, 65 -> `peak_0`=72. Then `clr_sticky[0]` with sample 30 -> `peak_0`=30.
